milano_muldiv: RTL and testbench
================================

MILANO_MULDIV -- requirements
Module: milano_muldiv

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the operand/result width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL derive localparam CW = $clog2(XLEN)+1 as the iteration-counter width.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  block can accept a request.
REQ-007 op_i  input  3  operation, RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 a_i  input  XLEN  rs1 operand (multiplicand or dividend).
REQ-009 b_i  input  XLEN  rs2 operand (multiplier or divisor).
REQ-010 kill_i  input  1  pipeline flush; aborts any operation in flight.
REQ-011 valid_o  output  1  result valid.
REQ-012 ready_i  input  1  consumer accepts result.
REQ-013 result_o  output  XLEN  operation result.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE; ready_o SHALL be 1 only in IDLE, and valid_o SHALL be 1 only in DONE.
REQ-015 A request is accepted when valid_i && ready_o && !kill_i; on acceptance the block SHALL latch the operand magnitudes, the result sign and op_i.
REQ-016 Signedness on acceptance SHALL be: a_i signed for MULH, MULHSU, DIV and REM; b_i signed for MULH, DIV and REM; all other operands unsigned.
REQ-017 After a normal accept the block SHALL enter CALC with counter = XLEN.
REQ-018 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle and decrement the counter; on the step where counter == 1 it SHALL go to DONE.
REQ-019 valid_o SHALL rise exactly XLEN+1 cycles after the accept edge.
REQ-020 Multiply results SHALL be: low XLEN bits of the 2*XLEN signed-corrected product for MUL; high XLEN bits for MULH, MULHSU and MULHU.
REQ-021 Divide results SHALL be sign-corrected per RISC-V: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-022 Divide-by-zero SHALL skip CALC and go IDLE->DONE, with valid_o asserted 1 cycle after accept; result = all ones for DIV and DIVU, a_i for REM and REMU.
REQ-023 Signed overflow (a = most-negative, b = -1, DIV or REM) SHALL also skip CALC; result = most-negative for DIV, 0 for REM.
REQ-024 In DONE, result_o SHALL hold stable while valid_o && !ready_i.
REQ-025 When valid_o && ready_i, the block SHALL return to IDLE; ready_o SHALL be 1 the following cycle, with no same-cycle re-accept.
REQ-026 kill_i in CALC or DONE SHALL force IDLE on the next edge with valid_o = 0 and no result delivered.
REQ-027 kill_i in IDLE SHALL block acceptance in that cycle.
REQ-028 kill_i SHALL take priority over ready_i.
REQ-029 When not in DONE, result_o SHALL be 0.

Reset
REQ-030 Asserting rst_ni low SHALL immediately force state = IDLE, counter = 0, all datapath registers = 0, valid_o = 0, result_o = 0 and ready_o = 1, including mid-CALC.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_ni deasserts.

Verification
REQ-032 XLEN=32, MUL a=7, b=-3, ready_i=1 -> valid_o high 33 cycles after accept, result 0xFFFFFFEB, ready_o 1 the next cycle.
REQ-033 XLEN=32, MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH with same operands -> 0x00000000; MULHSU a=-1, b=2 -> 0xFFFFFFFF.
REQ-034 XLEN=32, DIV a=-7, b=2 -> -3 (0xFFFFFFFD); REM with same operands -> -1; DIVU a=0x80000000, b=0 -> 0xFFFFFFFF with valid_o 1 cycle after accept; DIV a=0x80000000, b=-1 -> 0x80000000.
REQ-035 Accept DIVU 100/7, hold ready_i=0 for 5 cycles in DONE -> valid_o and result 14 stable throughout; ready_i=1 -> IDLE next cycle.
REQ-036 Pulse kill_i at CALC cycle 10 -> IDLE next edge, no valid_o; new MUL 3*4 -> 12; separately, drop rst_ni mid-CALC -> outputs immediately at reset values.
REQ-037 XLEN=8, DIV a=-128, b=3 -> result 0xD6 (-42) after 9 cycles; random signed/unsigned ops for XLEN = 8, 16, 32 and 64 SHALL match a reference model.

Source files
------------

// File: rtl/milano_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit. One radix-2 shift-add or
// restoring shift-subtract step per cycle, operating on operand magnitudes with a final sign fix.
module milano_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] f_cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_cneg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_negq;
  logic              r_negr;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_res;

  logic              w_accept;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_msum;
  logic [XLEN:0]     w_dsh;
  logic [XLEN-1:0]   w_dsub;
  logic              w_dge;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_final;

  assign w_accept = valid_i && (r_state == S_IDLE) && !kill_i;

  // Request decode: operand signedness, magnitudes and the two divide corner cases
  always_comb begin
    w_a_sgn    = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    w_b_sgn    = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    w_a_neg    = w_a_sgn && a_i[XLEN-1];
    w_b_neg    = w_b_sgn && b_i[XLEN-1];
    w_a_mag    = f_cneg(a_i, w_a_neg);
    w_b_mag    = f_cneg(b_i, w_b_neg);
    w_div0     = op_i[2] && (b_i == '0);
    w_ovf      = ((op_i == 3'd4) || (op_i == 3'd6)) && (a_i == MOST_NEG) && (b_i == '1);
    w_fast     = w_div0 || w_ovf;
    w_fast_res = '0;
    if (w_div0) begin
      w_fast_res = op_i[1] ? a_i : '1;
    end else if (w_ovf) begin
      w_fast_res = op_i[1] ? '0 : MOST_NEG;
    end
  end

  // One iteration step; lo holds multiplier (mul) or dividend/quotient (div)
  always_comb begin
    w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    w_dsh  = {r_hi, r_lo[XLEN-1]};
    w_dge  = w_dsh >= {1'b0, r_opnd};
    w_dsub = w_dsh[XLEN-1:0] - r_opnd;
    if (r_op[2]) begin
      w_hi_nxt = w_dge ? w_dsub : w_dsh[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_dge};
    end else begin
      w_hi_nxt = w_msum[XLEN:1];
      w_lo_nxt = {w_msum[0], r_lo[XLEN-1:1]};
    end
    w_prod = f_cneg2({w_hi_nxt, w_lo_nxt}, r_negq);
    if (r_op[2]) begin
      w_final = r_op[1] ? f_cneg(w_hi_nxt, r_negr) : f_cneg(w_lo_nxt, r_negq);
    end else begin
      w_final = (r_op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_res  <= '0;
    end else if (w_accept) begin
      r_op   <= op_i;
      r_negq <= w_a_neg ^ w_b_neg;
      r_negr <= w_a_neg;
      r_hi   <= '0;
      r_lo   <= op_i[2] ? w_a_mag : w_b_mag;
      r_opnd <= op_i[2] ? w_b_mag : w_a_mag;
      r_cnt  <= w_fast ? '0 : CW'(XLEN);
      r_res  <= w_fast_res;
    end else if ((r_state == S_CALC) && !kill_i) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        r_res <= w_final;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // kill_i outranks both completion and the result handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (kill_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (kill_i || ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (r_state == S_IDLE);
    valid_o  = (r_state == S_DONE);
    result_o = (r_state == S_DONE) ? r_res : '0;
  end

endmodule

// File: tb/tb_milano_muldiv.sv
// Bench for milano_muldiv: four instances (XLEN 8/16/32/64) driven with directed and
// random requests, checked against an arithmetic reference model and a per-cycle monitor.
module tb_milano_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vin    [4];
  logic        kill   [4];
  logic        rdy_in [4];
  logic [2:0]  op     [4];
  logic [63:0] a      [4];
  logic [63:0] b      [4];
  logic        rdy_o  [4];
  logic        vld_o  [4];
  logic [63:0] res    [4];

  logic [63:0] exp_res [4];
  bit          allow   [4];
  int d_chk = 0, d_err = 0, c_chk = 0, c_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = 8 << g;
    logic [W-1:0] w_res;
    milano_muldiv #(.XLEN(W)) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .valid_i  (vin[g]),
      .ready_o  (rdy_o[g]),
      .op_i     (op[g]),
      .a_i      (a[g][W-1:0]),
      .b_i      (b[g][W-1:0]),
      .kill_i   (kill[g]),
      .valid_o  (vld_o[g]),
      .ready_i  (rdy_in[g]),
      .result_o (w_res)
    );
    assign res[g] = 64'(w_res);
  end

  function automatic logic [63:0] msk(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: exact arithmetic on 130-bit signed values, RISC-V corner cases first
  function automatic logic [63:0] ref_op(input int w, input logic [2:0] o,
                                         input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] m, mn, ua, ub;
    logic signed [129:0] sa, sb, za, zb, p;
    logic [129:0] t;
    m  = msk(w);
    mn = 64'd1 << (w - 1);
    ua = ai & m;
    ub = bi & m;
    za = $signed({66'd0, ua});
    zb = $signed({66'd0, ub});
    sa = ua[w-1] ? (za - (130'sd1 <<< w)) : za;
    sb = ub[w-1] ? (zb - (130'sd1 <<< w)) : zb;
    if (o[2] && ub == 64'd0) return o[1] ? ua : m;
    if ((o == 3'd4 || o == 3'd6) && ua == mn && ub == m) return (o == 3'd4) ? mn : 64'd0;
    case (o)
      3'd0, 3'd1: p = sa * sb;
      3'd2:       p = sa * zb;
      3'd3:       p = za * zb;
      3'd4:       p = sa / sb;
      3'd5:       p = za / zb;
      3'd6:       p = sa % sb;
      default:    p = za % zb;
    endcase
    t = p;
    if (o inside {3'd1, 3'd2, 3'd3}) t = t >> w;
    return t[63:0] & m;
  endfunction

  function automatic bit is_fast(input int w, input logic [2:0] o,
                                 input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] m;
    m = msk(w);
    return o[2] && (((bi & m) == 64'd0) ||
           ((o == 3'd4 || o == 3'd6) && (ai & m) == (64'd1 << (w - 1)) && (bi & m) == m));
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] m;
    m = msk(w);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return m;
      3:       return 64'd1 << (w - 1);
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    d_chk++;
    if (got !== expv) begin
      d_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, expv);
    end
  endtask

  task automatic do_op(input int g, input logic [2:0] o, input logic [63:0] aa,
                       input logic [63:0] bb, input logic [63:0] expv, input int hold);
    int w, lat, n;
    bit got;
    w   = 8 << g;
    lat = is_fast(w, o, aa, bb) ? 1 : w + 1;
    @(negedge clk);
    chk("ready_before_accept", 64'(rdy_o[g]), 64'd1);
    op[g] = o; a[g] = aa; b[g] = bb;
    rdy_in[g]  = (hold == 0);
    exp_res[g] = expv;
    allow[g]   = 1'b1;
    vin[g]     = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      vin[g] = 1'b0;
      n++;
      got = vld_o[g];
    end
    chk("latency", 64'(n), 64'(lat));
    chk("result", res[g], expv);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(vld_o[g]), 64'd1);
      chk("hold_result", res[g], expv);
    end
    rdy_in[g] = 1'b1;
    @(negedge clk);
    chk("idle_after_handshake", 64'({vld_o[g], rdy_o[g]}), 64'b01);
    rdy_in[g] = 1'b0;
    allow[g]  = 1'b0;
  endtask

  // Per-cycle monitor: a valid result must be expected and correct, otherwise result_o is 0
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      for (int g = 0; g < 4; g++) begin
        c_chk++;
        if (vld_o[g] && (!allow[g] || res[g] !== exp_res[g])) begin
          c_err++;
          $display("FAIL monitor_result inst %0d: got %h (allowed %0b), expected %h",
                   g, res[g], allow[g], exp_res[g]);
        end else if (!vld_o[g] && res[g] !== 64'd0) begin
          c_err++;
          $display("FAIL monitor_idle_zero inst %0d: got %h, expected 0", g, res[g]);
        end else if (vld_o[g] && rdy_o[g]) begin
          c_err++;
          $display("FAIL monitor_ready_valid inst %0d: got both high, expected exclusive", g);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [2:0] o;
    logic [63:0] x, y;
    bit seen;
    rst_n = 1'b0;
    for (int g = 0; g < 4; g++) begin
      vin[g] = 1'b0; kill[g] = 1'b0; rdy_in[g] = 1'b0; op[g] = 3'd0;
      a[g] = 64'd0; b[g] = 64'd0; exp_res[g] = 64'd0; allow[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("reset_ready", 64'(rdy_o[g]), 64'd1);
      chk("reset_valid", 64'(vld_o[g]), 64'd0);
      chk("reset_result", res[g], 64'd0);
    end
    rst_n = 1'b1;

    chk("model_mul", ref_op(32, 3'd0, 64'd7, 64'hFFFF_FFFD), 64'hFFFF_FFEB);
    chk("model_mulhu", ref_op(32, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 64'hFFFF_FFFE);
    chk("model_mulh", ref_op(32, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 64'd0);
    chk("model_mulhsu", ref_op(32, 3'd2, 64'hFFFF_FFFF, 64'd2), 64'hFFFF_FFFF);
    chk("model_div", ref_op(32, 3'd4, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFD);
    chk("model_rem", ref_op(32, 3'd6, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF);
    chk("model_div8", ref_op(8, 3'd4, 64'h80, 64'd3), 64'hD6);

    do_op(2, 3'd0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 0);
    do_op(2, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 0);
    do_op(2, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 0);
    do_op(2, 3'd2, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF, 0);
    do_op(2, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 0);
    do_op(2, 3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 0);
    do_op(2, 3'd5, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF, 0);
    do_op(2, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 0);
    do_op(2, 3'd7, 64'd1234, 64'd0, 64'd1234, 1);
    do_op(2, 3'd5, 64'd100, 64'd7, 64'd14, 5);
    do_op(0, 3'd4, 64'h80, 64'd3, 64'hD6, 0);

    // Kill while idle: request must not be taken
    @(negedge clk);
    op[2] = 3'd0; a[2] = 64'd5; b[2] = 64'd6; vin[2] = 1'b1; kill[2] = 1'b1;
    @(negedge clk);
    vin[2] = 1'b0; kill[2] = 1'b0;
    chk("kill_idle_ready", 64'(rdy_o[2]), 64'd1);
    repeat (3) @(negedge clk);
    chk("kill_idle_no_valid", 64'(vld_o[2]), 64'd0);

    // Kill at CALC cycle 10
    @(negedge clk);
    op[2] = 3'd0; a[2] = 64'd5; b[2] = 64'd9; exp_res[2] = 64'd45; allow[2] = 1'b1; vin[2] = 1'b1;
    @(negedge clk);
    vin[2] = 1'b0;
    repeat (9) @(negedge clk);
    chk("kill_calc_busy", 64'(rdy_o[2]), 64'd0);
    kill[2] = 1'b1; allow[2] = 1'b0;
    @(negedge clk);
    kill[2] = 1'b0;
    chk("kill_calc_idle", 64'({vld_o[2], rdy_o[2]}), 64'b01);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (vld_o[2]) seen = 1'b1;
    end
    chk("kill_calc_no_valid", 64'(seen), 64'd0);
    do_op(2, 3'd0, 64'd3, 64'd4, 64'd12, 0);

    // Asynchronous reset mid-CALC, then accept on the first edge after release
    @(negedge clk);
    op[3] = 3'd5; a[3] = 64'd1000; b[3] = 64'd3; exp_res[3] = 64'd333; allow[3] = 1'b1; vin[3] = 1'b1;
    @(negedge clk);
    vin[3] = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_calc_busy", 64'(rdy_o[3]), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_calc_ready", 64'(rdy_o[3]), 64'd1);
    chk("rst_calc_valid", 64'(vld_o[3]), 64'd0);
    chk("rst_calc_result", res[3], 64'd0);
    allow[3] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_op(3, 3'd5, 64'd1000, 64'd3, 64'd333, 0);

    // Asynchronous reset while holding a result in DONE
    @(negedge clk);
    op[1] = 3'd0; a[1] = 64'd3; b[1] = 64'd4; exp_res[1] = 64'd12; allow[1] = 1'b1; vin[1] = 1'b1;
    @(negedge clk);
    vin[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_done_valid_before", 64'(vld_o[1]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_valid", 64'(vld_o[1]), 64'd0);
    chk("rst_done_result", res[1], 64'd0);
    chk("rst_done_ready", 64'(rdy_o[1]), 64'd1);
    allow[1] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int g = 0; g < 4; g++) begin
      w = 8 << g;
      for (int k = 0; k < 32; k++) begin
        o = 3'(k);
        x = rnd(w);
        y = rnd(w);
        do_op(g, o, x, y, ref_op(w, o, x, y), $urandom_range(0, 2));
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", d_chk + c_chk, d_err + c_err);
    $finish;
  end

endmodule
